image_ram_arbiter: RTL and testbench

//   Shares the single synchronous read port of the VGA image RAM between two

---
 rtl/image_ram_arbiter_if.sv | 32 +++
 rtl/image_ram_arbiter.sv | 73 +++++++
 tb/tb_image_ram_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/image_ram_arbiter_if.sv
// Bundle of both requester ports plus the image RAM read port.
// The slave modport is the arbiter's view; master is the requesters and RAM side.
interface image_ram_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
);
    logic              v_req;
    logic [ADDR_W-1:0] v_addr;
    logic              v_gnt;
    logic              v_rvalid;
    logic [DATA_W-1:0] v_rdata;
    logic              c_req;
    logic [ADDR_W-1:0] c_addr;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;
    logic              c_err;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_pixel;

    // req is a level held until gnt; the read is accepted in the cycle gnt is
    // high, and its data appears exactly two cycles later with rvalid.
    modport slave (
        input  v_req, v_addr, c_req, c_addr, ram_pixel,
        output v_gnt, v_rvalid, v_rdata, c_gnt, c_rvalid, c_rdata, c_err, ram_addr
    );

    modport master (
        output v_req, v_addr, c_req, c_addr, ram_pixel,
        input  v_gnt, v_rvalid, v_rdata, c_gnt, c_rvalid, c_rdata, c_err, ram_addr
    );
endinterface

// File: rtl/image_ram_arbiter.sv
// Shares the image RAM read port between the VGA fetcher (V, priority) and the CPU (C),
// with a starvation counter that forces a C grant, and a 2-stage return tag pipeline.
module image_ram_arbiter #(
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 45501,
    parameter int CPU_MAX_WAIT = 8,
    parameter int WAIT_W       = $clog2(CPU_MAX_WAIT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    image_ram_arbiter_if.slave bus,
    output logic [WAIT_W-1:0] dbg_wait_cnt
);

    typedef struct packed {
        logic vld;
        logic is_c;
        logic oor;
    } tag_t;

    localparam logic [ADDR_W:0]   DEPTH_X  = DEPTH[ADDR_W:0];
    localparam logic [WAIT_W-1:0] WAIT_MAX = CPU_MAX_WAIT[WAIT_W-1:0];

    logic [WAIT_W-1:0] wait_cnt;
    tag_t              stage1;
    tag_t              stage2;
    logic              force_c;
    logic              v_gnt_i;
    logic              c_gnt_i;
    logic [ADDR_W-1:0] gnt_addr;
    logic              gnt_oor;
    logic [DATA_W-1:0] ret_data;

    always_comb begin
        force_c  = (wait_cnt == WAIT_MAX);
        c_gnt_i  = bus.c_req & (force_c | ~bus.v_req);
        v_gnt_i  = bus.v_req & ~c_gnt_i;
        gnt_addr = c_gnt_i ? bus.c_addr : bus.v_addr;
        gnt_oor  = ({1'b0, gnt_addr} >= DEPTH_X);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt     <= '0;
            bus.ram_addr <= '0;
            stage1       <= '0;
            stage2       <= '0;
        end else begin
            // Counts consecutive denied C cycles; any C grant or idle C resets it.
            if (bus.c_req && !c_gnt_i) begin
                if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (v_gnt_i || c_gnt_i) bus.ram_addr <= gnt_addr;
            stage1 <= '{vld: v_gnt_i | c_gnt_i, is_c: c_gnt_i, oor: gnt_oor};
            stage2 <= stage1;
        end
    end

    // stage2 lines up with the RAM's registered output for the same read.
    assign ret_data     = stage2.oor ? '0 : bus.ram_pixel;
    assign bus.v_gnt    = v_gnt_i;
    assign bus.c_gnt    = c_gnt_i;
    assign bus.v_rvalid = stage2.vld & ~stage2.is_c;
    assign bus.c_rvalid = stage2.vld & stage2.is_c;
    assign bus.v_rdata  = bus.v_rvalid ? ret_data : '0;
    assign bus.c_rdata  = bus.c_rvalid ? ret_data : '0;
    assign bus.c_err    = bus.c_rvalid & stage2.oor;
    assign dbg_wait_cnt = wait_cnt;

endmodule

// File: tb/tb_image_ram_arbiter.sv
// Bench for image_ram_arbiter: directed table, starvation and reset sequences,
// then random traffic against a grant/return model.
module tb_image_ram_arbiter;

    localparam int AW    = 18;
    localparam int DW    = 32;
    localparam int DEPTH = 45501;
    localparam int MAXW  = 8;
    localparam int WW    = 4;
    localparam int EW    = 32 + 1 + AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [WW-1:0] dbg_wait_cnt;

    always #5 clk = ~clk;

    image_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    image_ram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .CPU_MAX_WAIT(MAXW), .WAIT_W(WW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .dbg_wait_cnt (dbg_wait_cnt)
    );

    function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
        logic [DW-1:0] t;
        t = {14'h1ABC, a};
        t = t * 32'h9E37_79B1;
        return t ^ 32'hC0FF_EE11;
    endfunction

    // Image RAM: one-cycle registered read.
    always_ff @(posedge clk) bus.ram_pixel <= pix(bus.ram_addr);

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int denied   = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive, check grants and returns at negedge, update the model.
    task automatic step(input logic vr, input logic [AW-1:0] va, input logic cr,
                        input logic [AW-1:0] ca, output logic vg_o, output logic cg_o);
        logic          fc, vg, cg, ev, ec, ee, is_c;
        logic [DW-1:0] ed;
        logic [AW-1:0] a;
        logic [EW-1:0] e;
        bus.v_req  = vr;
        bus.v_addr = va;
        bus.c_req  = cr;
        bus.c_addr = ca;
        @(negedge clk);
        fc = (denied == MAXW);
        cg = cr && (fc || !vr);
        vg = vr && !cg;
        check("v_gnt", bus.v_gnt, vg);
        check("c_gnt", bus.c_gnt, cg);
        check("wait_cnt", dbg_wait_cnt, denied);
        ev = 0; ec = 0; ee = 0; ed = '0;
        if (exp_q.size() > 0 && int'(exp_q[0][EW-1:AW+1]) == cyc) begin
            e    = exp_q.pop_front();
            is_c = e[AW];
            a    = e[AW-1:0];
            ed   = (int'(a) >= DEPTH) ? '0 : pix(a);
            ev   = !is_c;
            ec   = is_c;
            ee   = is_c && (int'(a) >= DEPTH);
        end
        check("v_rvalid", bus.v_rvalid, ev);
        check("c_rvalid", bus.c_rvalid, ec);
        check("v_rdata", bus.v_rdata, ev ? ed : '0);
        check("c_rdata", bus.c_rdata, ec ? ed : '0);
        check("c_err", bus.c_err, ee);
        if (cr && !cg) denied = (denied < MAXW) ? denied + 1 : MAXW;
        else denied = 0;
        if (vg || cg) exp_q.push_back({32'(cyc + 2), cg, cg ? ca : va});
        vg_o = bus.v_gnt;
        cg_o = bus.c_gnt;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        logic vg, cg;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, vg, cg);
    endtask

    task automatic do_reset(input int n);
        rst        = 1'b1;
        bus.v_req  = 1'b0;
        bus.c_req  = 1'b0;
        bus.v_addr = '0;
        bus.c_addr = '0;
        exp_q.delete();
        denied = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_outputs",
                  {bus.v_gnt, bus.c_gnt, bus.v_rvalid, bus.c_rvalid, bus.c_err, dbg_wait_cnt},
                  '0);
            check("rst_rdata", {bus.v_rdata, bus.c_rdata}, '0);
            check("rst_ram_addr", bus.ram_addr, '0);
            @(posedge clk);
            #1;
            cyc++;
        end
        rst = 1'b0;
    endtask

    typedef struct {
        logic          vr;
        logic [AW-1:0] va;
        logic          cr;
        logic [AW-1:0] ca;
        logic          evg;
        logic          ecg;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic vg, cg;
        int   c_cnt, c_first;
        rst        = 1'b1;
        bus.v_req  = 1'b0;
        bus.c_req  = 1'b0;
        bus.v_addr = '0;
        bus.c_addr = '0;
        #1;
        do_reset(2);

        tbl[0]  = '{1'b1, 18'd0,       1'b0, 18'd0,      1'b1, 1'b0};
        tbl[1]  = '{1'b1, 18'd1,       1'b0, 18'd0,      1'b1, 1'b0};
        tbl[2]  = '{1'b1, 18'd2,       1'b0, 18'd0,      1'b1, 1'b0};
        tbl[3]  = '{1'b0, 18'd0,       1'b1, 18'h100,    1'b0, 1'b1};
        tbl[4]  = '{1'b0, 18'd0,       1'b1, 18'd45501,  1'b0, 1'b1};
        tbl[5]  = '{1'b1, 18'h3FFFF,   1'b0, 18'd0,      1'b1, 1'b0};
        tbl[6]  = '{1'b0, 18'd0,       1'b1, 18'd45500,  1'b0, 1'b1};
        tbl[7]  = '{1'b0, 18'd0,       1'b0, 18'd0,      1'b0, 1'b0};
        tbl[8]  = '{1'b0, 18'd0,       1'b0, 18'd0,      1'b0, 1'b0};
        tbl[9]  = '{1'b1, 18'd7,       1'b1, 18'd9,      1'b1, 1'b0};
        tbl[10] = '{1'b0, 18'd0,       1'b1, 18'd9,      1'b0, 1'b1};
        tbl[11] = '{1'b0, 18'd0,       1'b0, 18'd0,      1'b0, 1'b0};
        foreach (tbl[i]) begin
            step(tbl[i].vr, tbl[i].va, tbl[i].cr, tbl[i].ca, vg, cg);
            check($sformatf("tbl%0d_v_gnt", i), vg, tbl[i].evg);
            check($sformatf("tbl%0d_c_gnt", i), cg, tbl[i].ecg);
        end
        idle(3);

        // Both ports held: C must win exactly every ninth cycle.
        c_cnt   = 0;
        c_first = -1;
        for (int i = 0; i < 3 * (MAXW + 1); i++) begin
            step(1'b1, AW'(16 + i), 1'b1, AW'(200 + i), vg, cg);
            if (cg) begin
                c_cnt++;
                if (c_first < 0) c_first = i;
            end
        end
        check("starve_c_count", c_cnt, 3);
        check("starve_c_first", c_first, MAXW);
        idle(3);

        // Reset one cycle after a grant: that read must never return.
        step(1'b1, 18'd5, 1'b1, 18'd6, vg, cg);
        do_reset(2);
        step(1'b1, 18'd33, 1'b0, 18'd0, vg, cg);
        check("post_rst_first_gnt", vg, 1'b1);
        idle(3);

        for (int i = 0; i < 500; i++) begin
            logic          vr, cr;
            logic [AW-1:0] va, ca;
            vr = ($urandom_range(0, 3) != 0);
            cr = ($urandom_range(0, 2) != 0);
            va = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEPTH, 2 ** AW - 1))
                                             : AW'($urandom_range(0, DEPTH - 1));
            ca = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(DEPTH, 2 ** AW - 1))
                                             : AW'($urandom_range(0, DEPTH - 1));
            step(vr, va, cr, ca, vg, cg);
            if (i == 250) do_reset(1);
        end
        idle(3);
        check("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
